// File: rtl/top_level_module.sv
// Single-clock FIFO with registered read data and registered status flags.
// Dropped writes (full) and dropped reads (empty) raise a one-cycle pulse.
module top_level_module #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  FIFO_clk,
   input  logic                  FIFO_reset_n,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  FIFO_w_en,
   output logic                  FIFO_full,
   input  logic                  FIFO_r_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  FIFO_empty,
   output logic                  FIFO_overflow,
   output logic                  FIFO_underflow
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned PTR_W = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wptr;
   logic [PTR_W-1:0]      rptr;
   logic [PTR_W-1:0]      wptr_nxt_c;
   logic [PTR_W-1:0]      rptr_nxt_c;
   logic                  wr_acc_c;
   logic                  rd_acc_c;
   logic                  empty_nxt_c;
   logic                  full_nxt_c;

   // Accept decisions use the registered flags; the extra pointer MSB tells full from empty.
   always_comb begin
      wr_acc_c    = FIFO_w_en & ~FIFO_full;
      rd_acc_c    = FIFO_r_en & ~FIFO_empty;
      wptr_nxt_c  = wptr + PTR_W'(wr_acc_c);
      rptr_nxt_c  = rptr + PTR_W'(rd_acc_c);
      empty_nxt_c = (wptr_nxt_c == rptr_nxt_c);
      full_nxt_c  = (wptr_nxt_c[ADDR_WIDTH-1:0] == rptr_nxt_c[ADDR_WIDTH-1:0]) &&
                    (wptr_nxt_c[ADDR_WIDTH] != rptr_nxt_c[ADDR_WIDTH]);
   end

   // Storage is intentionally not reset.
   always_ff @(posedge FIFO_clk) begin
      if (wr_acc_c) begin
         mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
      end
   end

   always_ff @(posedge FIFO_clk or negedge FIFO_reset_n) begin
      if (!FIFO_reset_n) begin
         wptr           <= '0;
         rptr           <= '0;
         data_out       <= '0;
         FIFO_empty     <= 1'b1;
         FIFO_full      <= 1'b0;
         FIFO_overflow  <= 1'b0;
         FIFO_underflow <= 1'b0;
      end else begin
         wptr           <= wptr_nxt_c;
         rptr           <= rptr_nxt_c;
         FIFO_empty     <= empty_nxt_c;
         FIFO_full      <= full_nxt_c;
         FIFO_overflow  <= FIFO_w_en & FIFO_full;
         FIFO_underflow <= FIFO_r_en & FIFO_empty;
         if (rd_acc_c) begin
            data_out <= mem[rptr[ADDR_WIDTH-1:0]];
         end
      end
   end

endmodule

// File: tb/tb_top_level_module.sv
// Directed self-checking bench for the synchronous FIFO.
module tb_top_level_module;

   logic        clk;
   logic        rst_n;
   logic [15:0] din;
   logic        w_en;
   logic        r_en;
   logic [15:0] dout;
   logic        full;
   logic        empty;
   logic        ovf;
   logic        unf;

   int checks   = 0;
   int failures = 0;

   top_level_module #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
      .FIFO_clk       (clk),
      .FIFO_reset_n   (rst_n),
      .data_in        (din),
      .FIFO_w_en      (w_en),
      .FIFO_full      (full),
      .FIFO_r_en      (r_en),
      .data_out       (dout),
      .FIFO_empty     (empty),
      .FIFO_overflow  (ovf),
      .FIFO_underflow (unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs from a falling edge; outputs are sampled at the next falling edge.
   task automatic step(input logic w, input logic [15:0] d, input logic r);
      w_en = w;
      din  = d;
      r_en = r;
      @(negedge clk);
      w_en = 1'b0;
      r_en = 1'b0;
   endtask

   task automatic check_flags(input string tag, input logic e, input logic f,
                              input logic o, input logic u);
      check({tag, "_empty"}, 32'(empty), 32'(e));
      check({tag, "_full"},  32'(full),  32'(f));
      check({tag, "_ovf"},   32'(ovf),   32'(o));
      check({tag, "_unf"},   32'(unf),   32'(u));
   endtask

   logic [15:0] fill [16];

   initial begin
      rst_n = 1'b0;
      w_en  = 1'b0;
      r_en  = 1'b0;
      din   = '0;
      for (int i = 0; i < 15; i++) fill[i] = 16'(16'h1111 * (i + 1));
      fill[15] = 16'h1112;

      // Reset state
      repeat (2) @(negedge clk);
      check_flags("rst", 1'b1, 1'b0, 1'b0, 1'b0);
      check("rst_dout", 32'(dout), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single write then single read
      step(1'b1, 16'h1111, 1'b0);
      check_flags("wr1", 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1);
      check("rd1_dout", 32'(dout), 32'h1111);
      check_flags("rd1", 1'b1, 1'b0, 1'b0, 1'b0);

      // Fill to full
      for (int i = 0; i < 16; i++) begin
         step(1'b1, fill[i], 1'b0);
         if (i == 14) check("fill15_full", 32'(full), 32'h0);
      end
      check_flags("fill16", 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 16'h1113, 1'b0);
      check_flags("ovf_pulse", 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      check_flags("ovf_clear", 1'b0, 1'b1, 1'b0, 1'b0);

      // Drain in order
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 16'h0, 1'b1);
         check($sformatf("drain%0d", i), 32'(dout), 32'(fill[i]));
         if (i == 0) check("drain0_full", 32'(full), 32'h0);
      end
      check_flags("drained", 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1);
      check_flags("unf_pulse", 1'b1, 1'b0, 1'b0, 1'b1);
      check("unf_dout", 32'(dout), 32'h1112);
      step(1'b0, 16'h0, 1'b0);
      check_flags("unf_clear", 1'b1, 1'b0, 1'b0, 1'b0);

      // Simultaneous write/read on empty: write only
      step(1'b1, 16'h5A5A, 1'b1);
      check_flags("wr_rd_empty", 1'b0, 1'b0, 1'b0, 1'b1);
      check("wr_rd_empty_dout", 32'(dout), 32'h1112);
      step(1'b0, 16'h0, 1'b1);
      check("wr_rd_empty_rd", 32'(dout), 32'h5A5A);
      check_flags("wr_rd_empty_after", 1'b1, 1'b0, 1'b0, 1'b0);

      // Streaming at occupancy 3 across pointer wrap
      for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 16'(16'h0103 + i), 1'b1);
         check($sformatf("stream%0d", i), 32'(dout), 32'(16'h0100 + i));
         check_flags($sformatf("stream%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 16'h0, 1'b1);
         check($sformatf("stream_tail%0d", i), 32'(dout), 32'(16'h0128 + i));
      end
      check_flags("stream_done", 1'b1, 1'b0, 1'b0, 1'b0);

      // Simultaneous write/read on full: read only
      for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h3000 + i), 1'b0);
      check("refill_full", 32'(full), 32'h1);
      step(1'b1, 16'hBEEF, 1'b1);
      check_flags("wr_rd_full", 1'b0, 1'b0, 1'b1, 1'b0);
      check("wr_rd_full_dout", 32'(dout), 32'h3000);
      for (int i = 1; i < 16; i++) begin
         step(1'b0, 16'h0, 1'b1);
         check($sformatf("full_drain%0d", i), 32'(dout), 32'(16'h3000 + i));
      end
      check_flags("full_drained", 1'b1, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-stream
      step(1'b1, 16'h7777, 1'b0);
      step(1'b1, 16'h8888, 1'b0);
      w_en = 1'b1;
      din  = 16'h9999;
      #2 rst_n = 1'b0;
      #1;
      check_flags("async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
      check("async_rst_dout", 32'(dout), 32'h0);
      w_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      step(1'b1, 16'h2222, 1'b0);
      step(1'b1, 16'h3333, 1'b0);
      step(1'b1, 16'h4444, 1'b0);
      step(1'b0, 16'h0, 1'b1);
      check("post_rst_rd0", 32'(dout), 32'h2222);
      step(1'b0, 16'h0, 1'b1);
      check("post_rst_rd1", 32'(dout), 32'h3333);
      step(1'b0, 16'h0, 1'b1);
      check("post_rst_rd2", 32'(dout), 32'h4444);
      check_flags("post_rst_end", 1'b1, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
